// File: rtl/uart_alu_interface_pkg.sv
// Shared types and constants for the UART-to-ALU frame collector:
// FSM state encoding, ALU opcode values and the timeout counter width helper.
package uart_alu_interface_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_e;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_NOR = 6'h27;

   // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
   function automatic int timeout_cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bundle of the rx/ALU/tx signals seen by the frame collector.
// master = surrounding uart_rx/alu/uart_tx side, slave = the collector.
interface uart_alu_interface_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
);
   logic               i_rx_done;
   logic [NB_DATA-1:0] i_rx_data;
   logic [NB_DATA-1:0] i_alu_result;
   logic               i_tx_done;
   logic [NB_DATA-1:0] o_data_a;
   logic [NB_DATA-1:0] o_data_b;
   logic [NB_OP-1:0]   o_op;
   logic               o_tx_start;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_busy;
   logic               o_timeout;
   logic               o_drop;

   modport master (
      output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
      input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_timeout, o_drop
   );

   modport slave (
      input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
      output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_timeout, o_drop
   );
endinterface

// File: rtl/uart_alu_interface_timeout.sv
// Inter-byte timeout counter: counts while enabled, saturates instead of wrapping,
// and flags expiry on the last allowed cycle. TIMEOUT_CYCLES=0 never expires.
module uart_alu_interface_timeout
   import uart_alu_interface_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW   = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];
   localparam logic          ENABLED  = (TIMEOUT_CYCLES > 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != '1))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = ENABLED && en_i && (cnt_q == CNT_LAST);
endmodule

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from uart_rx, presents them to the
// ALU, then hands the captured result to uart_tx with a start/done handshake.
module uart_alu_interface
   import uart_alu_interface_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   uart_alu_interface_if.slave  bus
);
   state_e             state_q;
   logic [NB_DATA-1:0] data_a_q;
   logic [NB_DATA-1:0] data_b_q;
   logic [NB_OP-1:0]   op_q;
   logic [NB_DATA-1:0] tx_data_q;
   logic               tx_start_q;
   logic               busy_q;
   logic               timeout_q;
   logic               drop_q;

   logic               collecting;
   logic               expired;

   // Timer runs only between bytes of a frame; any accepted byte restarts it.
   assign collecting = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

   uart_alu_interface_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .clr_i     (!collecting || bus.i_rx_done),
      .en_i      (collecting),
      .expired_o (expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_WAIT_A;
         data_a_q   <= '0;
         data_b_q   <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         // busy_q is high exactly in EXEC/SEND/WAIT_TX, where bytes are discarded.
         drop_q     <= bus.i_rx_done && busy_q;
         case (state_q)
            ST_WAIT_A: begin
               if (bus.i_rx_done) begin
                  data_a_q <= bus.i_rx_data;
                  state_q  <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (bus.i_rx_done) begin
                  data_b_q <= bus.i_rx_data;
                  state_q  <= ST_WAIT_OP;
               end else if (expired) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_WAIT_A;
               end
            end
            ST_WAIT_OP: begin
               if (bus.i_rx_done) begin
                  op_q    <= bus.i_rx_data[NB_OP-1:0];
                  busy_q  <= 1'b1;
                  state_q <= ST_EXEC;
               end else if (expired) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_WAIT_A;
               end
            end
            ST_EXEC: begin
               tx_data_q <= bus.i_alu_result;
               state_q   <= ST_SEND;
            end
            ST_SEND: begin
               tx_start_q <= 1'b1;
               state_q    <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (bus.i_tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_A;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_WAIT_A;
            end
         endcase
      end
   end

   assign bus.o_data_a   = data_a_q;
   assign bus.o_data_b   = data_b_q;
   assign bus.o_op       = op_q;
   assign bus.o_tx_start = tx_start_q;
   assign bus.o_tx_data  = tx_data_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_timeout  = timeout_q;
   assign bus.o_drop     = drop_q;
endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: ALU model, scripted uart_tx done pulse
// 20 cycles after start, frame/timeout/drop/reset scenarios.
module tb_uart_alu_interface;
   import uart_alu_interface_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) ifc ();

   uart_alu_interface #(
      .NB_DATA        (8),
      .NB_OP          (6),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (ifc)
   );

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOR:  return ~(a | b);
         OP_SRL:  return a >> b;
         OP_SRA:  return 8'($signed(a) >>> b);
         default: return 8'h00;
      endcase
   endfunction

   assign ifc.i_alu_result = alu_model(ifc.o_data_a, ifc.o_data_b, ifc.o_op);

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".data_a"},   ifc.o_data_a, 8'h00);
      chk({tag, ".data_b"},   ifc.o_data_b, 8'h00);
      chk({tag, ".op"},       8'(ifc.o_op), 8'h00);
      chk({tag, ".tx_start"}, 8'(ifc.o_tx_start), 8'h00);
      chk({tag, ".tx_data"},  ifc.o_tx_data, 8'h00);
      chk({tag, ".busy"},     8'(ifc.o_busy), 8'h00);
      chk({tag, ".timeout"},  8'(ifc.o_timeout), 8'h00);
      chk({tag, ".drop"},     8'(ifc.o_drop), 8'h00);
   endtask

   // Presents a byte for one clock edge; returns just after that edge.
   task automatic send_byte(input logic [7:0] b);
      ifc.i_rx_done = 1'b1;
      ifc.i_rx_data = b;
      @(negedge clk);
      ifc.i_rx_done = 1'b0;
      ifc.i_rx_data = 8'h00;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Sends the opcode byte and plays uart_tx; optionally injects a byte in WAIT_TX.
   task automatic finish_frame(input string tag, input logic [7:0] op, input logic [7:0] exp,
                               input bit inject, input logic [7:0] exp_a);
      int extra_start;
      int extra_drop;
      extra_start = 0;
      extra_drop  = 0;
      send_byte(op);
      chk({tag, ".op"},         8'(ifc.o_op), {2'b00, op[5:0]});
      chk({tag, ".busy_exec"},  8'(ifc.o_busy), 8'h01);
      chk({tag, ".start_exec"}, 8'(ifc.o_tx_start), 8'h00);
      @(negedge clk);
      chk({tag, ".start_send"}, 8'(ifc.o_tx_start), 8'h00);
      chk({tag, ".tx_data"},    ifc.o_tx_data, exp);
      @(negedge clk);
      chk({tag, ".start"},      8'(ifc.o_tx_start), 8'h01);
      for (int i = 1; i < 20; i++) begin
         if (inject && i == 5) begin
            ifc.i_rx_done = 1'b1;
            ifc.i_rx_data = 8'hAA;
         end
         @(negedge clk);
         ifc.i_rx_done = 1'b0;
         ifc.i_rx_data = 8'h00;
         if (inject && i == 5) begin
            chk({tag, ".drop"},       8'(ifc.o_drop), 8'h01);
            chk({tag, ".busy_drop"},  8'(ifc.o_busy), 8'h01);
            chk({tag, ".a_kept"},     ifc.o_data_a, exp_a);
         end else if (ifc.o_drop) begin
            extra_drop++;
         end
         if (ifc.o_tx_start) extra_start++;
      end
      chk({tag, ".tx_held"},     ifc.o_tx_data, exp);
      ifc.i_tx_done = 1'b1;
      @(negedge clk);
      ifc.i_tx_done = 1'b0;
      chk({tag, ".busy_done"},   8'(ifc.o_busy), 8'h00);
      chk({tag, ".extra_start"}, 8'(extra_start), 8'h00);
      chk({tag, ".extra_drop"},  8'(extra_drop), 8'h00);
      $display("[TB] %s: op=%02h tx_data=%02h", tag, op, ifc.o_tx_data);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp, input bit inject);
      send_byte(a);
      chk({tag, ".data_a"}, ifc.o_data_a, a);
      chk({tag, ".busy_a"}, 8'(ifc.o_busy), 8'h00);
      send_byte(b);
      chk({tag, ".data_b"}, ifc.o_data_b, b);
      finish_frame(tag, op, exp, inject, a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int early;
      int seen;
      ifc.i_rx_done = 1'b0;
      ifc.i_rx_data = 8'h00;
      ifc.i_tx_done = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_all_zero("reset");

      // Basic ADD frame
      run_frame("t1_add", 8'h05, 8'h03, 8'h20, 8'h08, 1'b0);

      // Partial frame abandoned after 50 idle cycles in WAIT_B
      send_byte(8'h11);
      chk("t2.data_a", ifc.o_data_a, 8'h11);
      early = 0;
      for (int i = 1; i < 50; i++) begin
         @(negedge clk);
         if (ifc.o_timeout) early++;
      end
      chk("t2.early_timeout", 8'(early), 8'h00);
      @(negedge clk);
      chk("t2.timeout",     8'(ifc.o_timeout), 8'h01);
      chk("t2.a_kept",      ifc.o_data_a, 8'h11);
      @(negedge clk);
      chk("t2.timeout_end", 8'(ifc.o_timeout), 8'h00);
      repeat (8) @(negedge clk);
      run_frame("t2_sub", 8'h02, 8'h02, 8'h22, 8'h00, 1'b0);

      // Byte arriving during WAIT_TX is dropped; following frame unaffected
      run_frame("t3_and_drop", 8'h07, 8'h09, 8'h24, 8'h01, 1'b1);
      run_frame("t3_xor", 8'h0A, 8'h05, 8'h26, 8'h0F, 1'b0);

      // Reset while in WAIT_OP
      send_byte(8'h33);
      send_byte(8'h44);
      pulse_reset();
      chk_all_zero("t4_reset");
      send_byte(8'h20);
      chk("t4.byte_is_a", ifc.o_data_a, 8'h20);
      chk("t4.op_zero",   8'(ifc.o_op), 8'h00);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (ifc.o_tx_start || ifc.o_busy) seen++;
      end
      chk("t4.no_start", 8'(seen), 8'h00);
      pulse_reset();

      // Byte coincides with the expiry cycle in WAIT_B
      send_byte(8'h01);
      repeat (49) @(negedge clk);
      send_byte(8'h5A);
      chk("t5.data_b",  ifc.o_data_b, 8'h5A);
      chk("t5.timeout", 8'(ifc.o_timeout), 8'h00);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.o_timeout) seen++;
      end
      chk("t5.no_timeout_op", 8'(seen), 8'h00);
      finish_frame("t5_add", 8'h20, 8'h5B, 1'b0, 8'h01);

      // Back-to-back frames; stray tx_done in WAIT_B is ignored
      send_byte(8'hFF);
      ifc.i_tx_done = 1'b1;
      @(negedge clk);
      ifc.i_tx_done = 1'b0;
      chk("t6.txdone_ignored", 8'(ifc.o_busy), 8'h00);
      send_byte(8'h01);
      chk("t6.data_b", ifc.o_data_b, 8'h01);
      finish_frame("t6_add_wrap", 8'h20, 8'h00, 1'b0, 8'hFF);
      run_frame("t6_or", 8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
